// File: rtl/armaria_flags_pkg.sv
// Shared status-flag definitions: flag word layout, halt pattern and the
// flag-register update modes driven by the control unit.
package armaria_flags_pkg;

  localparam int unsigned FLAG_W = 5;

  localparam int unsigned FLAG_N = 4;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_M = 0;

  localparam logic [FLAG_W-1:0] FLAGS_HALT = 5'h1f;

  typedef enum logic [1:0] {
    FlagHold    = 2'd0,
    FlagLoad    = 2'd1,
    FlagRestore = 2'd2,
    FlagHalt    = 2'd3
  } flag_upd_e;

  function automatic logic [FLAG_W-1:0] flags_pack(input logic n, input logic z, input logic c,
                                                   input logic v, input logic m);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_M] = m;
    return f;
  endfunction

endpackage

// File: rtl/flag_lifo_mem.sv
// Register array backing the flag context stack: one synchronous write port,
// one asynchronous read port, cleared on reset.
module flag_lifo_mem #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FLAG_W = 5,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [FLAG_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [FLAG_W-1:0] rdata
);

  logic [FLAG_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/flag_context_stack.sv
// LIFO of processor status flags for exception/SWI nesting, with a one-cycle
// restore beat on pop and sticky overflow/underflow indications.
module flag_context_stack #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FLAG_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [FLAG_W-1:0]        flags_in,
  input  logic                     clear_err,
  output logic                     restore_valid,
  output logic [FLAG_W-1:0]        restore_flags,
  output logic [FLAG_W-1:0]        top_flags,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow_err,
  output logic                     underflow_err
);
  import armaria_flags_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;
  localparam logic [DW-1:0] DepthMax = DW'(DEPTH);

  logic [DW-1:0]     depth_q, depth_d;
  logic [FLAG_W-1:0] rflags_q, rflags_d;
  logic              rvalid_q, rvalid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [AW-1:0]     top_idx;
  logic [FLAG_W-1:0] top_rd;
  logic              ovf_set, unf_set;

  assign empty   = (depth_q == '0);
  assign full    = (depth_q == DepthMax);
  // When empty this index aliases a stale slot; top_flags masks it below.
  assign top_idx = AW'(depth_q - DW'(1));

  flag_lifo_mem #(
    .DEPTH  (DEPTH),
    .FLAG_W (FLAG_W),
    .AW     (AW)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (flags_in),
    .raddr (top_idx),
    .rdata (top_rd)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = depth_q[AW-1:0];
    depth_d   = depth_q;
    rflags_d  = rflags_q;
    rvalid_d  = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;

    if (push && pop) begin
      rvalid_d = 1'b1;
      if (empty) begin
        rflags_d = flags_in;
      end else begin
        // Swap: restore the top and overwrite it in place, depth unchanged.
        rflags_d  = top_rd;
        mem_we    = 1'b1;
        mem_waddr = top_idx;
      end
    end else if (push) begin
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        mem_we  = 1'b1;
        depth_d = depth_q + DW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        rvalid_d = 1'b1;
        rflags_d = top_rd;
        depth_d  = depth_q - DW'(1);
      end
    end

    ovf_d = ovf_set | (ovf_q & ~clear_err);
    unf_d = unf_set | (unf_q & ~clear_err);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q  <= '0;
      rflags_q <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      depth_q  <= depth_d;
      rflags_q <= rflags_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign top_flags     = empty ? '0 : top_rd;
  assign depth         = depth_q;
  assign restore_valid = rvalid_q;
  assign restore_flags = rflags_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_flag_context_stack.sv
// Directed and randomized check of flag_context_stack against a queue model.
module tb_flag_context_stack;

  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic       push;
  logic       pop;
  logic [4:0] flags_in;
  logic       clear_err;
  logic       restore_valid;
  logic [4:0] restore_flags;
  logic [4:0] top_flags;
  logic [2:0] depth;
  logic       empty;
  logic       full;
  logic       overflow_err;
  logic       underflow_err;

  flag_context_stack #(
    .DEPTH  (DEPTH),
    .FLAG_W (5)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .push          (push),
    .pop           (pop),
    .flags_in      (flags_in),
    .clear_err     (clear_err),
    .restore_valid (restore_valid),
    .restore_flags (restore_flags),
    .top_flags     (top_flags),
    .depth         (depth),
    .empty         (empty),
    .full          (full),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the stack as a queue, top at the back.
  logic [4:0] q[$];
  logic       m_rv;
  logic [4:0] m_rf;
  logic       m_ovf;
  logic       m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic pu, input logic po, input logic [4:0] f,
                              input logic clr);
    logic so, su;
    so = 1'b0;
    su = 1'b0;
    if (r) begin
      q.delete();
      m_rv  = 1'b0;
      m_rf  = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (pu && po) begin
        m_rv = 1'b1;
        if (q.size() > 0) begin
          m_rf = q[q.size()-1];
          q[q.size()-1] = f;
        end else begin
          m_rf = f;
        end
      end else if (pu) begin
        if (q.size() < DEPTH) q.push_back(f);
        else so = 1'b1;
      end else if (po) begin
        if (q.size() > 0) begin
          m_rf = q.pop_back();
          m_rv = 1'b1;
        end else begin
          su = 1'b1;
        end
      end
      m_ovf = so | (m_ovf & ~clr);
      m_unf = su | (m_unf & ~clr);
    end
  endtask

  task automatic compare_all();
    logic [4:0] exp_top;
    exp_top = (q.size() > 0) ? q[q.size()-1] : 5'h00;
    check("restore_valid", 32'(restore_valid), 32'(m_rv));
    check("restore_flags", 32'(restore_flags), 32'(m_rf));
    check("depth", 32'(depth), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("top_flags", 32'(top_flags), 32'(exp_top));
    check("overflow_err", 32'(overflow_err), 32'(m_ovf));
    check("underflow_err", 32'(underflow_err), 32'(m_unf));
  endtask

  // Called just after a negedge; inputs stay stable across the next posedge.
  task automatic step(input logic r, input logic pu, input logic po, input logic [4:0] f,
                      input logic clr);
    reset     = r;
    push      = pu;
    pop       = po;
    flags_in  = f;
    clear_err = clr;
    @(posedge clock);
    model_update(r, pu, po, f, clr);
    #1;
    compare_all();
    @(negedge clock);
  endtask

  initial begin
    reset     = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    flags_in  = '0;
    clear_err = 1'b0;
    q.delete();
    m_rv  = 1'b0;
    m_rf  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clock);

    // 1: reset, single push/pop round trip
    step(1, 0, 0, 5'h00, 0);
    check("t1_reset_depth", 32'(depth), 32'd0);
    step(0, 1, 0, 5'b10100, 0);
    step(0, 0, 1, 5'h00, 0);
    check("t1_rf", 32'(restore_flags), 32'h14);
    check("t1_empty", 32'(empty), 32'd1);
    step(0, 0, 0, 5'h00, 0);
    check("t1_rv_drop", 32'(restore_valid), 32'd0);

    // 2: fill, overflow, drain in LIFO order
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 5'(i), 0);
    check("t2_full", 32'(full), 32'd1);
    step(0, 1, 0, 5'h1f, 0);
    check("t2_ovf", 32'(overflow_err), 32'd1);
    check("t2_depth", 32'(depth), 32'd4);
    for (int i = 4; i >= 1; i--) begin
      step(0, 0, 1, 5'h00, 0);
      check("t2_order", 32'(restore_flags), 32'(i));
    end

    // 3: underflow, clear vs set priority
    step(0, 0, 0, 5'h00, 1);
    step(0, 0, 1, 5'h00, 0);
    check("t3_unf", 32'(underflow_err), 32'd1);
    check("t3_rv", 32'(restore_valid), 32'd0);
    step(0, 0, 1, 5'h00, 1);
    check("t3_set_wins", 32'(underflow_err), 32'd1);
    step(0, 0, 0, 5'h00, 1);
    check("t3_cleared", 32'(underflow_err), 32'd0);

    // 4: swap and empty bypass
    step(0, 1, 0, 5'h0a, 0);
    step(0, 1, 1, 5'h15, 0);
    check("t4_swap_rf", 32'(restore_flags), 32'h0a);
    check("t4_swap_top", 32'(top_flags), 32'h15);
    step(0, 0, 1, 5'h00, 0);
    step(0, 1, 1, 5'h07, 0);
    check("t4_bypass_rf", 32'(restore_flags), 32'h07);
    check("t4_bypass_depth", 32'(depth), 32'd0);

    // 5: reset dominates a pop mid-sequence
    for (int i = 0; i < 3; i++) step(0, 1, 0, 5'(5'h11 + i), 0);
    step(1, 0, 1, 5'h00, 0);
    check("t5_rst_depth", 32'(depth), 32'd0);
    check("t5_rst_rv", 32'(restore_valid), 32'd0);
    step(0, 0, 1, 5'h00, 0);
    check("t5_unf", 32'(underflow_err), 32'd1);

    // 6: random stream
    for (int i = 0; i < 1000; i++) begin
      step(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           logic'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
